cva6_cfg_readback: RTL and testbench
====================================

// Module: cva6_cfg_readback
// PURPOSE
//  Read-side counterpart of the build-time configuration derivation: exposes the derived
//  config_pkg::cva6_cfg_t to software/debug/test infrastructure at run time. Packs the fields into
//  fixed 32-bit words. Serves them through a single-cycle indexed read port and a valid/ready
//  dump stream. Sits beside the CSR/debug logic; it holds no architectural state.
// PARAMETERS
//  CVA6Cfg    config_pkg::cva6_cfg_empty  derived core config to publish (compile-time constant)
//  NrWords    13 (14 with CRC_EN)   words in map; localparam, not overridable
// PORTS
//  clk_i          in   1   core clock
//  rst_ni         in   1   asynchronous reset, active low
//  rd_req_i       in   1   indexed read request
//  rd_addr_i      in   4   word index
//  rd_valid_o     out  1   read response valid, one cycle after rd_req_i
//  rd_data_o      out  32  read response data
//  rd_err_o       out  1   response for index >= NrWords; data forced 0
//  dump_start_i   in   1   start full-map stream (pulse)
//  dump_flush_i   in   1   abort stream
//  dump_valid_o   out  1   stream word valid
//  dump_ready_i   in   1   stream consumer ready
//  dump_data_o    out  32  stream word
//  dump_last_o    out  1   current stream word is final
//  dump_busy_o    out  1   stream active
//  dump_done_o    out  1   one-cycle pulse after the last word handshakes
// BEHAVIOUR
//  Word map: 0 magic 32'hC7A6_CF61.
//   1 flags [0]RVA [1]RVB [2]RVC [3]RVD [4]RVF [5]RVH [6]RVS [7]RVU [8]RVV [9]RVZCB [10]RVZCMP
//     [11]XF16 [12]XF16ALT [13]XF8 [14]XFVec [15]CvxifEn [16]ZiCondExtEn [17]FpPresent [18]NSX
//     [19]EnableAccelerator [20]DebugEn [21]TvalEn [22]NonIdemPotenceEn [23]AxiBurstWriteEn, [31:24]=0.
//   2 {NrRgprPorts,NrWbPorts,NrCommitPorts,FLen} one byte each, MSB..LSB.
//   3 {AxiUserWidth,AxiIdWidth,AxiDataWidth,AxiAddrWidth} one byte each, MSB..LSB.
//   4 {MaxOutstandingStores,NrLoadBufEntries,NrPMPEntries,RASDepth} one byte each, MSB..LSB.
//   5 {BHTEntries[15:0],BTBEntries[15:0]}.
//   6 {NOCType[7:0],MEM_TID_WIDTH[7:0],DCACHE_MAX_TX[15:0]}.
//   7/8 HaltAddress lo/hi. 9/10 ExceptionAddress lo/hi. 11/12 DmBaseAddress lo/hi.
//  Width rule: a field wider than its lane saturates to all-ones; never truncates. 64-bit addresses zero-extend.
//  Read port: always accepted, no back-pressure. rd_valid_o/rd_data_o/rd_err_o register on the cycle after rd_req_i.
//   Back-to-back requests give back-to-back responses. rd_valid_o=0 in any cycle after no request.
//  Dump FSM: IDLE -> STREAM on dump_start_i, idx<=0.
//   STREAM: dump_valid_o=1 and dump_data_o=word[idx]. dump_last_o=(idx==NrWords-1).
//   On valid&ready, idx++. On the handshake of the last word: -> IDLE and dump_done_o=1 next cycle.
//   Data/last hold stable while valid&!ready.
//  Boundaries:
//   - dump_start_i while STREAM: ignored.
//   - dump_flush_i in any state: -> IDLE next cycle, no done pulse. Flush wins over a same-cycle start.
//   - Flush coincident with the last-word handshake: the word counts as consumed; still no done pulse.
//  The read port and the stream are independent; concurrent use is legal.
//  Reset (async, any state): all outputs 0, FSM IDLE, idx 0. A stream cut by reset is not resumed.
// CONFIGURATION
//  CVA6_CFG_READBACK_CRC_EN defined:
//   - word 13 = two's-complement of the 32-bit sum of words 0..12, so all 14 words sum to 0 mod 2^32.
//   - NrWords=14; stream ends on word 13; rd_addr_i=13 valid.
//  Undefined: NrWords=13; rd_addr_i 13..15 return rd_err_o=1.
// STRUCTURE
//  Package cva6_cfg_readback_pkg:
//   - word-index localparams, CFG_MAGIC
//   - dump_state_e {IDLE,STREAM}
//   - function sat_lane(value,width) for lane saturation
//  Sub-module cva6_cfg_word_rom: combinational index -> word table built from CVA6Cfg; instanced twice (read port, stream).
// TESTING
//  - rd_req_i with addr 0 -> next cycle rd_valid_o=1, rd_data_o=32'hC7A6_CF61, rd_err_o=0.
//  - Config RVC=1, RVF=1, RVD=1, FpuEn=1, RVS=1, RVU=1, rest 0; read addr 1 -> bits 2,3,4,6,7,17 set only.
//  - Read addr 15 -> rd_err_o=1, rd_data_o=0; addr 13 gives the same unless CRC_EN.
//  - dump_start_i with ready held 1 -> 13 consecutive words matching reads; last on word 12; done pulses once.
//  - Stream with ready toggling 1/0 every other cycle -> data stable while stalled; no word lost or duplicated.
//  - Flush at idx 5, then start -> restarts at word 0; also check async reset mid-stream and (CRC_EN) that 14 words sum to 0.

Source files
------------

// File: rtl/config_pkg.sv
// Configuration record published by the readback block: the fields of the derived CVA6 config
// that the readback word map exposes, with an all-zero default configuration.
package config_pkg;

    typedef struct packed {
        bit          RVA, RVB, RVC, RVD, RVF, RVH, RVS, RVU, RVV, RVZCB, RVZCMP;
        bit          XF16, XF16ALT, XF8, XFVec, CvxifEn, ZiCondExtEn, FpPresent, NSX;
        bit          EnableAccelerator, DebugEn, TvalEn, NonIdemPotenceEn, AxiBurstWriteEn;
        int unsigned FLen, NrCommitPorts, NrWbPorts, NrRgprPorts;
        int unsigned AxiAddrWidth, AxiDataWidth, AxiIdWidth, AxiUserWidth;
        int unsigned RASDepth, NrPMPEntries, NrLoadBufEntries, MaxOutstandingStores;
        int unsigned BTBEntries, BHTEntries;
        int unsigned DCACHE_MAX_TX, MEM_TID_WIDTH, NOCType;
        logic [63:0] HaltAddress, ExceptionAddress, DmBaseAddress;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cva6_cfg_readback_pkg.sv
// Word map layout, dump FSM states and lane saturation for cva6_cfg_readback.
// CVA6_CFG_READBACK_CRC_EN appends a checksum word so the whole map sums to zero.
package cva6_cfg_readback_pkg;

    localparam logic [31:0] CFG_MAGIC = 32'hC7A6_CF61;

    localparam int unsigned WORD_MAGIC   = 0;
    localparam int unsigned WORD_FLAGS   = 1;
    localparam int unsigned WORD_PORTS   = 2;
    localparam int unsigned WORD_AXI     = 3;
    localparam int unsigned WORD_DEPTHS  = 4;
    localparam int unsigned WORD_BP      = 5;
    localparam int unsigned WORD_NOC     = 6;
    localparam int unsigned WORD_HALT_LO = 7;
    localparam int unsigned WORD_HALT_HI = 8;
    localparam int unsigned WORD_EXC_LO  = 9;
    localparam int unsigned WORD_EXC_HI  = 10;
    localparam int unsigned WORD_DM_LO   = 11;
    localparam int unsigned WORD_DM_HI   = 12;
`ifdef CVA6_CFG_READBACK_CRC_EN
    localparam int unsigned WORD_CRC     = 13;
    localparam int unsigned NR_WORDS     = 14;
`else
    localparam int unsigned NR_WORDS     = 13;
`endif

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned MAP_DEPTH = 16;

    typedef logic [MAP_DEPTH-1:0][31:0] word_map_t;

    typedef enum logic {
        IDLE,
        STREAM
    } dump_state_e;

    // Clamp a value to the largest number a width-bit lane can hold instead of truncating it.
    function automatic logic [31:0] sat_lane(input int unsigned value, input int unsigned width);
        logic [32:0] lane_max;
        lane_max = (33'd1 << width) - 33'd1;
        if ({1'b0, value} > lane_max) return lane_max[31:0];
        return value;
    endfunction

endpackage

// File: rtl/cva6_cfg_readback_if.sv
// Read port and dump stream of cva6_cfg_readback; slave is the readback block, master its user.
interface cva6_cfg_readback_if import cva6_cfg_readback_pkg::*;;

    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              rd_valid_o;
    logic [31:0]       rd_data_o;
    logic              rd_err_o;

    logic              dump_start_i;
    logic              dump_flush_i;
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [31:0]       dump_data_o;
    logic              dump_last_o;
    logic              dump_busy_o;
    logic              dump_done_o;

    modport slave (
        input  rd_req_i, rd_addr_i, dump_start_i, dump_flush_i, dump_ready_i,
        output rd_valid_o, rd_data_o, rd_err_o,
        output dump_valid_o, dump_data_o, dump_last_o, dump_busy_o, dump_done_o
    );

    modport master (
        output rd_req_i, rd_addr_i, dump_start_i, dump_flush_i, dump_ready_i,
        input  rd_valid_o, rd_data_o, rd_err_o,
        input  dump_valid_o, dump_data_o, dump_last_o, dump_busy_o, dump_done_o
    );

endinterface

// File: rtl/cva6_cfg_word_rom.sv
// Combinational word-index -> config word table, elaborated entirely from CVA6Cfg.
// Indices past the map read as zero and flag err_o.
module cva6_cfg_word_rom
    import cva6_cfg_readback_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [31:0]       word_o,
    output logic              err_o
);

    function automatic logic [7:0] lane8(input int unsigned value);
        logic [31:0] sat;
        sat = sat_lane(value, 8);
        return sat[7:0];
    endfunction

    function automatic logic [15:0] lane16(input int unsigned value);
        logic [31:0] sat;
        sat = sat_lane(value, 16);
        return sat[15:0];
    endfunction

    function automatic word_map_t build_map(input config_pkg::cva6_cfg_t cfg);
        word_map_t map;
`ifdef CVA6_CFG_READBACK_CRC_EN
        logic [31:0] sum;
`endif
        map = '0;
        map[WORD_MAGIC]   = CFG_MAGIC;
        map[WORD_FLAGS]   = {8'h00,
                             cfg.AxiBurstWriteEn, cfg.NonIdemPotenceEn, cfg.TvalEn, cfg.DebugEn,
                             cfg.EnableAccelerator, cfg.NSX, cfg.FpPresent, cfg.ZiCondExtEn,
                             cfg.CvxifEn, cfg.XFVec, cfg.XF8, cfg.XF16ALT,
                             cfg.XF16, cfg.RVZCMP, cfg.RVZCB, cfg.RVV,
                             cfg.RVU, cfg.RVS, cfg.RVH, cfg.RVF,
                             cfg.RVD, cfg.RVC, cfg.RVB, cfg.RVA};
        map[WORD_PORTS]   = {lane8(cfg.NrRgprPorts), lane8(cfg.NrWbPorts),
                             lane8(cfg.NrCommitPorts), lane8(cfg.FLen)};
        map[WORD_AXI]     = {lane8(cfg.AxiUserWidth), lane8(cfg.AxiIdWidth),
                             lane8(cfg.AxiDataWidth), lane8(cfg.AxiAddrWidth)};
        map[WORD_DEPTHS]  = {lane8(cfg.MaxOutstandingStores), lane8(cfg.NrLoadBufEntries),
                             lane8(cfg.NrPMPEntries), lane8(cfg.RASDepth)};
        map[WORD_BP]      = {lane16(cfg.BHTEntries), lane16(cfg.BTBEntries)};
        map[WORD_NOC]     = {lane8(cfg.NOCType), lane8(cfg.MEM_TID_WIDTH),
                             lane16(cfg.DCACHE_MAX_TX)};
        map[WORD_HALT_LO] = cfg.HaltAddress[31:0];
        map[WORD_HALT_HI] = cfg.HaltAddress[63:32];
        map[WORD_EXC_LO]  = cfg.ExceptionAddress[31:0];
        map[WORD_EXC_HI]  = cfg.ExceptionAddress[63:32];
        map[WORD_DM_LO]   = cfg.DmBaseAddress[31:0];
        map[WORD_DM_HI]   = cfg.DmBaseAddress[63:32];
`ifdef CVA6_CFG_READBACK_CRC_EN
        sum = '0;
        for (int i = 0; i < WORD_CRC; i++) sum += map[i];
        map[WORD_CRC] = 32'd0 - sum;
`endif
        return map;
    endfunction

    // NOTE: the table is an elaboration-time constant, so it needs no reset and holds no state.
    localparam word_map_t WordMap = build_map(CVA6Cfg);

    assign word_o = WordMap[addr_i];
    assign err_o  = 32'(addr_i) >= NR_WORDS;

endmodule

// File: rtl/cva6_cfg_readback.sv
// Publishes the derived core config as a fixed word map via a one-cycle read port and a
// valid/ready dump stream. Build with CVA6_CFG_READBACK_CRC_EN to append the checksum word.
module cva6_cfg_readback
    import cva6_cfg_readback_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cva6_cfg_readback_if.slave   bus
);

    localparam int unsigned       NrWords = NR_WORDS;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NrWords - 1);

    logic [31:0]       rd_word, stream_word;
    logic              rd_err, stream_err;

    logic              rd_valid_d, rd_valid_q;
    logic [31:0]       rd_data_d, rd_data_q;
    logic              rd_err_d, rd_err_q;

    dump_state_e       state_d, state_q;
    logic [ADDR_W-1:0] idx_d, idx_q;
    logic              done_d, done_q;
    logic              stream_active;

    cva6_cfg_word_rom #(.CVA6Cfg(CVA6Cfg)) i_rd_rom (
        .addr_i (bus.rd_addr_i),
        .word_o (rd_word),
        .err_o  (rd_err)
    );

    cva6_cfg_word_rom #(.CVA6Cfg(CVA6Cfg)) i_stream_rom (
        .addr_i (idx_q),
        .word_o (stream_word),
        .err_o  (stream_err)
    );

    always_comb begin
        rd_valid_d = bus.rd_req_i;
        rd_data_d  = bus.rd_req_i ? rd_word : '0;
        rd_err_d   = bus.rd_req_i & rd_err;
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dump_start_i) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (bus.dump_ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        // Flush beats a same-cycle start and swallows the done pulse of a final handshake.
        if (bus.dump_flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            state_q    <= IDLE;
            idx_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            done_q     <= done_d;
        end
    end

    assign stream_active = (state_q == STREAM);

    assign bus.rd_valid_o   = rd_valid_q;
    assign bus.rd_data_o    = rd_data_q;
    assign bus.rd_err_o     = rd_err_q;

    assign bus.dump_valid_o = stream_active;
    assign bus.dump_busy_o  = stream_active;
    assign bus.dump_data_o  = (stream_active && !stream_err) ? stream_word : '0;
    assign bus.dump_last_o  = stream_active && (idx_q == LastIdx);
    assign bus.dump_done_o  = done_q;

endmodule

// File: tb/tb_cva6_cfg_readback.sv
// Self-checking bench for cva6_cfg_readback: directed and random traffic on the read port and
// dump stream, compared against a word-map model derived from the published config.
module tb_cva6_cfg_readback;
    import config_pkg::*;

`ifdef CVA6_CFG_READBACK_CRC_EN
    localparam int NR = 14;
`else
    localparam int NR = 13;
`endif

    function automatic cva6_cfg_t make_cfg();
        cva6_cfg_t c;
        c = '0;
        c.RVC = 1'b1; c.RVD = 1'b1; c.RVF = 1'b1; c.FpPresent = 1'b1; c.RVS = 1'b1; c.RVU = 1'b1;
        c.FLen = 64; c.NrCommitPorts = 2; c.NrWbPorts = 5; c.NrRgprPorts = 3;
        c.AxiAddrWidth = 64; c.AxiDataWidth = 64; c.AxiIdWidth = 4; c.AxiUserWidth = 300;
        c.RASDepth = 2; c.NrPMPEntries = 8; c.NrLoadBufEntries = 2; c.MaxOutstandingStores = 7;
        c.BTBEntries = 32; c.BHTEntries = 70000;
        c.DCACHE_MAX_TX = 8; c.MEM_TID_WIDTH = 5; c.NOCType = 1;
        c.HaltAddress      = 64'h0000_0000_0000_0800;
        c.ExceptionAddress = 64'hDEAD_0001_0000_0808;
        c.DmBaseAddress    = 64'h0000_0001_0000_0000;
        return c;
    endfunction

    localparam cva6_cfg_t TB_CFG = make_cfg();

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cva6_cfg_readback_if bus();

    cva6_cfg_readback #(.CVA6Cfg(TB_CFG)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference word map, computed straight from the field/lane rules.
    logic [31:0] exp_w [16];

    function automatic logic [31:0] sat(input longint unsigned v, input int bits);
        longint unsigned top;
        top = (64'd1 << bits) - 64'd1;
        return (v > top) ? top[31:0] : v[31:0];
    endfunction

    task automatic build_model();
        bit fl [24];
        logic [31:0] sum;
        cva6_cfg_t c;
        c = TB_CFG;
        for (int i = 0; i < 16; i++) exp_w[i] = '0;
        exp_w[0] = 32'hC7A6_CF61;
        fl = '{c.RVA, c.RVB, c.RVC, c.RVD, c.RVF, c.RVH, c.RVS, c.RVU, c.RVV, c.RVZCB, c.RVZCMP,
               c.XF16, c.XF16ALT, c.XF8, c.XFVec, c.CvxifEn, c.ZiCondExtEn, c.FpPresent, c.NSX,
               c.EnableAccelerator, c.DebugEn, c.TvalEn, c.NonIdemPotenceEn, c.AxiBurstWriteEn};
        for (int i = 0; i < 24; i++) if (fl[i]) exp_w[1] += 32'd1 << i;
        exp_w[2] = sat(c.NrRgprPorts, 8) * 32'h0100_0000 + sat(c.NrWbPorts, 8) * 32'h1_0000
                 + sat(c.NrCommitPorts, 8) * 32'h100 + sat(c.FLen, 8);
        exp_w[3] = sat(c.AxiUserWidth, 8) * 32'h0100_0000 + sat(c.AxiIdWidth, 8) * 32'h1_0000
                 + sat(c.AxiDataWidth, 8) * 32'h100 + sat(c.AxiAddrWidth, 8);
        exp_w[4] = sat(c.MaxOutstandingStores, 8) * 32'h0100_0000
                 + sat(c.NrLoadBufEntries, 8) * 32'h1_0000
                 + sat(c.NrPMPEntries, 8) * 32'h100 + sat(c.RASDepth, 8);
        exp_w[5] = sat(c.BHTEntries, 16) * 32'h1_0000 + sat(c.BTBEntries, 16);
        exp_w[6] = sat(c.NOCType, 8) * 32'h0100_0000 + sat(c.MEM_TID_WIDTH, 8) * 32'h1_0000
                 + sat(c.DCACHE_MAX_TX, 16);
        exp_w[7]  = 32'(c.HaltAddress % 64'h1_0000_0000);
        exp_w[8]  = 32'(c.HaltAddress / 64'h1_0000_0000);
        exp_w[9]  = 32'(c.ExceptionAddress % 64'h1_0000_0000);
        exp_w[10] = 32'(c.ExceptionAddress / 64'h1_0000_0000);
        exp_w[11] = 32'(c.DmBaseAddress % 64'h1_0000_0000);
        exp_w[12] = 32'(c.DmBaseAddress / 64'h1_0000_0000);
        sum = '0;
        for (int i = 0; i < 13; i++) sum += exp_w[i];
        if (NR == 14) exp_w[13] = 32'd0 - sum;
    endtask

    // Stream model: whether a dump is in progress, which map word is on offer, done expected.
    bit          m_active = 1'b0;
    int          m_pos = 0;
    bit          m_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] rx_q [$];

    task automatic cycle(input bit start, input bit flush, input bit ready,
                         input bit req, input logic [3:0] addr);
        bit          finish;
        logic [31:0] sum;
        bus.rd_req_i     = req;
        bus.rd_addr_i    = addr;
        bus.dump_start_i = start;
        bus.dump_flush_i = flush;
        bus.dump_ready_i = ready;
        if (m_active && ready) rx_q.push_back(bus.dump_data_o);
        prev_stall = m_active && !ready && !flush;
        prev_data  = bus.dump_data_o;
        finish = 1'b0;
        if (flush) begin
            m_active = 1'b0;
            m_pos    = 0;
            rx_q.delete();
        end else if (m_active) begin
            if (ready) begin
                if (m_pos == NR - 1) begin
                    m_active = 1'b0;
                    m_pos    = 0;
                    finish   = 1'b1;
                end else begin
                    m_pos++;
                end
            end
        end else if (start) begin
            m_active = 1'b1;
            m_pos    = 0;
            rx_q.delete();
        end
        m_done = finish;
        @(posedge clk);
        #1;
        check("rd_valid", 32'(bus.rd_valid_o), 32'(req));
        if (req) begin
            check("rd_data", bus.rd_data_o, (32'(addr) < NR) ? exp_w[addr] : 32'd0);
            check("rd_err", 32'(bus.rd_err_o), 32'(32'(addr) >= NR));
        end
        check("dump_valid", 32'(bus.dump_valid_o), 32'(m_active));
        check("dump_busy", 32'(bus.dump_busy_o), 32'(m_active));
        check("dump_last", 32'(bus.dump_last_o), 32'(m_active && m_pos == NR - 1));
        if (m_active) check("dump_data", bus.dump_data_o, exp_w[m_pos]);
        check("dump_done", 32'(bus.dump_done_o), 32'(m_done));
        if (prev_stall) check("stall_hold", bus.dump_data_o, prev_data);
        if (finish) begin
            check("rx_count", 32'(rx_q.size()), 32'(NR));
            sum = '0;
            for (int i = 0; i < rx_q.size() && i < NR; i++) begin
                check("rx_word", rx_q[i], exp_w[i]);
                sum += rx_q[i];
            end
`ifdef CVA6_CFG_READBACK_CRC_EN
            check("crc_sum", sum, 32'd0);
`endif
            rx_q.delete();
        end
    endtask

    initial begin
        build_model();
        bus.rd_req_i     = 1'b0;
        bus.rd_addr_i    = '0;
        bus.dump_start_i = 1'b0;
        bus.dump_flush_i = 1'b0;
        bus.dump_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        check("rst_rd_data", bus.rd_data_o, 32'd0);
        check("rst_rd_err", 32'(bus.rd_err_o), 32'd0);
        check("rst_dump_valid", 32'(bus.dump_valid_o), 32'd0);
        check("rst_dump_data", bus.dump_data_o, 32'd0);
        check("rst_dump_last", 32'(bus.dump_last_o), 32'd0);
        check("rst_dump_busy", 32'(bus.dump_busy_o), 32'd0);
        check("rst_dump_done", 32'(bus.dump_done_o), 32'd0);
        rst_n = 1'b1;

        // Fixed-value reads: magic, flags of the sample config, out-of-range indices.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("magic_const", bus.rd_data_o, 32'hC7A6_CF61);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        check("flags_const", bus.rd_data_o, 32'h0002_00DC);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        check("addr15_err", 32'(bus.rd_err_o), 32'd1);
        check("addr15_data", bus.rd_data_o, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd13);
`ifdef CVA6_CFG_READBACK_CRC_EN
        check("addr13_err", 32'(bus.rd_err_o), 32'd0);
`else
        check("addr13_err", 32'(bus.rd_err_o), 32'd1);
        check("addr13_data", bus.rd_data_o, 32'd0);
`endif
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int a = 0; a < 16; a++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'(a));

        // Full dump with the consumer always ready.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        repeat (NR + 2) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Ready toggling every other cycle, with a stray start mid-stream.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 2 * NR + 4; i++) cycle(i == 3, 1'b0, (i % 2) == 0, 1'b1, 4'(i % 16));

        // Flush at word 5, restart from word 0, flush on the last handshake, flush beats start.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("pre_flush_word5", bus.dump_data_o, exp_w[5]);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        check("restart_word0", bus.dump_data_o, exp_w[0]);
        repeat (NR - 1) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Random concurrent traffic on both ports.
        repeat (400)
            cycle($urandom_range(9) == 0, $urandom_range(39) == 0, $urandom_range(9) < 6,
                  $urandom_range(1) == 1, 4'($urandom_range(15)));

        // Asynchronous reset in the middle of a stream; the stream must not resume.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        check("async_rd_data", bus.rd_data_o, 32'd0);
        check("async_dump_valid", 32'(bus.dump_valid_o), 32'd0);
        check("async_dump_busy", 32'(bus.dump_busy_o), 32'd0);
        check("async_dump_data", bus.dump_data_o, 32'd0);
        m_active   = 1'b0;
        m_pos      = 0;
        m_done     = 1'b0;
        prev_stall = 1'b0;
        rx_q.delete();
        bus.rd_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        repeat (NR + 1) cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
